// File: rtl/vx_raster_stamp_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vx_raster_stamp_packer_pkg
//  Brief    : Shared stamp type, stamp width and packer state encoding for
//             the raster stamp packer.
//  Revision : 1.0 - initial release
// ============================================================================
package vx_raster_stamp_packer_pkg;

  localparam int RASTER_DIM_BITS   = 12;
  localparam int RASTER_MASK_BITS  = 4;
  localparam int RASTER_PID_BITS   = 8;
  localparam int RASTER_BCRD_BITS  = 32;

  typedef struct packed {
    logic [RASTER_DIM_BITS-1:0]  pos_x;
    logic [RASTER_DIM_BITS-1:0]  pos_y;
    logic [RASTER_MASK_BITS-1:0] mask;
    logic [RASTER_PID_BITS-1:0]  pid;
    logic [RASTER_BCRD_BITS-1:0] bcoords;
  } raster_stamp_t;

  localparam int RASTER_STAMP_BITS = $bits(raster_stamp_t);

  // Packer state encoding
  localparam logic [1:0] c_ST_FILL = 2'd0;
  localparam logic [1:0] c_ST_FULL = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/vx_raster_stamp_packer_if.sv
`default_nettype none
// ============================================================================
//  Module   : vx_raster_stamp_packer_if
//  Brief    : Raster bus request side: packed multi-lane stamp packet with
//             valid/ready handshake and a done flag.
//  Revision : 1.0 - initial release
// ============================================================================
interface vx_raster_stamp_packer_if #(
  parameter int NUM_LANES = 4
);
  import vx_raster_stamp_packer_pkg::*;

  logic                                   req_valid;
  logic [NUM_LANES*RASTER_STAMP_BITS-1:0] req_stamps;
  logic                                   req_done;
  logic                                   req_ready;

  modport master (
    output req_valid,
    output req_stamps,
    output req_done,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_stamps,
    input  req_done,
    output req_ready
  );

endinterface
`default_nettype wire

// File: rtl/vx_raster_stamp_packer.sv
`default_nettype none
// ============================================================================
//  Module   : vx_raster_stamp_packer
//  Brief    : Gathers single raster stamps into NUM_LANES-wide bus packets,
//             flushes partial packets on idle timeout or end-of-work, and
//             holds a sticky done packet once the raster unit completes.
//  Revision : 1.0 - initial release
// ============================================================================
module vx_raster_stamp_packer
  import vx_raster_stamp_packer_pkg::*;
#(
  parameter int NUM_LANES     = 4,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  wire logic                     clk,
  input  wire logic                     reset,
  input  wire logic                     start,
  input  wire logic                     in_valid,
  input  raster_stamp_t                 in_stamp,
  output logic                          in_ready,
  input  wire logic                     in_done,
  vx_raster_stamp_packer_if.master      bus
);

  localparam int CNT_W  = $clog2(NUM_LANES + 1);
  localparam int IDLE_W = $clog2(FLUSH_TIMEOUT + 1);

  logic [1:0]                     r_state;
  logic [CNT_W-1:0]               r_cnt;
  logic [IDLE_W-1:0]              r_idle;
  raster_stamp_t [NUM_LANES-1:0]  r_lanes;
  logic [CNT_W-1:0]               w_cnt_inc;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Packet assembly, idle timeout flush and done/start sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_ST_FILL;
      r_cnt   <= '0;
      r_idle  <= '0;
      r_lanes <= '0;
    end else begin
      case (r_state)
        c_ST_FILL: begin
          if (in_valid) begin
            // Stamps take priority over in_done so none is ever dropped
            for (int i = 0; i < NUM_LANES; i++) begin
              if (r_cnt == CNT_W'(i)) r_lanes[i] <= in_stamp;
            end
            r_cnt  <= w_cnt_inc;
            r_idle <= '0;
            if (w_cnt_inc == CNT_W'(NUM_LANES)) r_state <= c_ST_FULL;
          end else if (in_done) begin
            r_state <= (r_cnt != '0) ? c_ST_FULL : c_ST_DONE;
          end else if (r_cnt != '0) begin
            if (r_idle == IDLE_W'(FLUSH_TIMEOUT - 1)) begin
              r_state <= c_ST_FULL;
            end else if (r_idle != '1) begin
              r_idle <= r_idle + IDLE_W'(1);
            end
          end
        end
        c_ST_FULL: begin
          if (bus.req_ready) begin
            r_lanes <= '0;
            r_cnt   <= '0;
            r_idle  <= '0;
            r_state <= c_ST_FILL;
          end
        end
        c_ST_DONE: begin
          // Handshakes here are acknowledged without leaving DONE
          if (start) r_state <= c_ST_FILL;
        end
        default: r_state <= c_ST_FILL;
      endcase
    end
  end

  // Output view decoded from state; lane data only shown while FULL
  always_comb begin
    in_ready       = (r_state == c_ST_FILL);
    bus.req_valid  = (r_state != c_ST_FILL);
    bus.req_done   = (r_state == c_ST_DONE);
    bus.req_stamps = '0;
    if (r_state == c_ST_FULL) bus.req_stamps = r_lanes;
  end

`ifndef SYNTHESIS
  // The raster unit must not emit stamps after reporting completion
  a_no_stamp_in_done: assert property (@(posedge clk) disable iff (reset)
    !(r_state == c_ST_DONE && in_valid));
`endif

endmodule
`default_nettype wire

// File: tb/tb_vx_raster_stamp_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vx_raster_stamp_packer
//  Brief    : Directed self-checking bench for vx_raster_stamp_packer
//             (NUM_LANES=4, FLUSH_TIMEOUT=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vx_raster_stamp_packer;
  import vx_raster_stamp_packer_pkg::*;

  localparam int NL = 4;
  localparam int FT = 8;
  localparam int SB = RASTER_STAMP_BITS;
  localparam int W  = NL * SB;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  raster_stamp_t in_stamp;
  logic          in_ready;
  logic          in_done;

  int n_err = 0;
  int n_chk = 0;

  vx_raster_stamp_packer_if #(.NUM_LANES(NL)) bus ();

  vx_raster_stamp_packer #(
    .NUM_LANES     (NL),
    .FLUSH_TIMEOUT (FT)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_stamp (in_stamp),
    .in_ready (in_ready),
    .in_done  (in_done),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic raster_stamp_t mk(input int pid);
    raster_stamp_t s;
    s.pos_x   = 12'(pid * 3);
    s.pos_y   = 12'(pid * 7 + 1);
    s.mask    = 4'(pid) | 4'h1;
    s.pid     = 8'(pid);
    s.bcoords = 32'h1000_0000 + 32'(pid);
    return s;
  endfunction

  function automatic logic [W-1:0] pkt(input int p0, input int p1, input int p2,
                                       input int p3, input int n);
    logic [W-1:0] v;
    int p[4];
    p = '{p0, p1, p2, p3};
    v = '0;
    for (int i = 0; i < n; i++) v[i*SB +: SB] = mk(p[i]);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int pid);
    in_valid = 1'b1;
    in_stamp = mk(pid);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    in_valid      = 1'b0;
    in_stamp      = '0;
    in_done       = 1'b0;
    bus.req_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_req_valid", bus.req_valid, 0);
    check("rst_req_done", bus.req_done, 0);
    check("rst_req_stamps", bus.req_stamps, 0);
    reset = 1'b0;

    // 1: four back-to-back stamps, agent always ready
    bus.req_ready = 1'b1;
    send(1); send(2); send(3); send(4);
    check("t1_valid", bus.req_valid, 1);
    check("t1_stamps", bus.req_stamps, pkt(1, 2, 3, 4, 4));
    check("t1_done", bus.req_done, 0);
    check("t1_in_ready_low", in_ready, 0);
    tick();
    check("t1_in_ready_back", in_ready, 1);
    check("t1_valid_low", bus.req_valid, 0);

    // 2: two stamps then idle -> partial flush 8 cycles after last accept
    bus.req_ready = 1'b0;
    send(5); send(6);
    repeat (FT - 1) tick();
    check("t2_not_yet", bus.req_valid, 0);
    tick();
    check("t2_valid", bus.req_valid, 1);
    check("t2_stamps", bus.req_stamps, pkt(5, 6, 0, 0, 2));
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    check("t2_in_ready", in_ready, 1);

    // 4: backpressure while FULL, pending stamp lands in lane 0 afterwards
    send(7); send(8); send(9); send(10);
    check("t4_valid", bus.req_valid, 1);
    in_valid = 1'b1;
    in_stamp = mk(11);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_stable", bus.req_stamps, pkt(7, 8, 9, 10, 4));
      check("t4_in_ready_low", in_ready, 0);
    end
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    check("t4_in_ready_back", in_ready, 1);
    tick();
    in_valid = 1'b0;
    send(12); send(13); send(14);
    check("t4_lane0", bus.req_stamps, pkt(11, 12, 13, 14, 4));
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;

    // 5: in_valid and in_done together with cnt=3
    send(20); send(21); send(22);
    in_valid = 1'b1;
    in_stamp = mk(23);
    in_done  = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t5_valid", bus.req_valid, 1);
    check("t5_done", bus.req_done, 0);
    check("t5_stamps", bus.req_stamps, pkt(20, 21, 22, 23, 4));
    bus.req_ready = 1'b1;
    tick();
    check("t5_fill", bus.req_valid, 0);
    tick();
    check("t5_done_valid", bus.req_valid, 1);
    check("t5_done_flag", bus.req_done, 1);
    check("t5_done_stamps", bus.req_stamps, 0);
    in_done = 1'b0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    bus.req_ready = 1'b0;
    check("t5_restart", in_ready, 1);

    // 3: three stamps then end-of-work -> partial packet, then sticky DONE
    send(30); send(31); send(32);
    in_done = 1'b1;
    tick();
    check("t3_valid", bus.req_valid, 1);
    check("t3_done", bus.req_done, 0);
    check("t3_stamps", bus.req_stamps, pkt(30, 31, 32, 0, 3));
    bus.req_ready = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t3_sticky_valid", bus.req_valid, 1);
      check("t3_sticky_done", bus.req_done, 1);
      check("t3_sticky_stamps", bus.req_stamps, 0);
      tick();
    end
    in_done = 1'b0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    bus.req_ready = 1'b0;
    check("t3_restart", in_ready, 1);

    // 6: reset in the middle of FULL, then DONE and start into a new packet
    send(40); send(41); send(42); send(43);
    check("t6_full", bus.req_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_in_ready", in_ready, 1);
    check("t6_rst_valid", bus.req_valid, 0);
    check("t6_rst_stamps", bus.req_stamps, 0);
    reset = 1'b0;
    in_done = 1'b1;
    tick();
    check("t6_done", bus.req_done, 1);
    in_done = 1'b0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check("t6_fill", in_ready, 1);
    send(50); send(51); send(52); send(53);
    check("t6_valid", bus.req_valid, 1);
    check("t6_stamps", bus.req_stamps, pkt(50, 51, 52, 53, 4));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
